countdown_16bit: RTL

- Loadable 16-bit down-counting timer: the counterpart to the lab's free-running up-counter.
- Loaded from switches, decremented once per prescaled tick, stops at zero and flags completion.
- Drives four active-low hex digits from the current count through a shared hex-to-segment encoder.
- Sits at lab top level: SW to D, KEY pushbuttons to Load/Start/Pause (debounced externally), outputs to HEX3..HEX0 and an LED.

---
 rtl/countdown_16bit_pkg.sv | 17 +
 rtl/countdown_16bit_hex_to_seg.sv | 33 +++
 rtl/countdown_16bit.sv | 105 ++++++++++
 3 files changed

// File: rtl/countdown_16bit_pkg.sv
// Shared definitions for the loadable countdown timer and its hex display.
// State codes are fixed because lab debug probes decode them directly.
package countdown_16bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_DIGITS = 4;
  localparam int         DIGIT_W    = 4;
  localparam int         PRE_W      = 26;

endpackage

// File: rtl/countdown_16bit_hex_to_seg.sv
// Hex nibble to active-low 7-segment encoder (bit0=a .. bit6=g).
// Shared with the up-counter display; lowercase b and d keep them distinct from 8 and 0.
module hex_to_seg
  import countdown_16bit_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_16bit.sv
// Loadable 16-bit down-counting timer with prescaled ticks, pause and done flag.
// Drives four active-low hex digits straight from the live count.
module countdown_16bit
  import countdown_16bit_pkg::*;
#(
  parameter int DIV   = 50000000,
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             Load,
  input  logic             Start,
  input  logic             Pause,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Running,
  output logic             Done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         q_nxt;
  logic [PRE_W-1:0]         pre, pre_nxt;
  logic                     tick;
  logic [NUM_DIGITS-1:0][6:0] seg;

  assign tick = (pre == PRE_LAST);

  // Load beats everything; Pause beats a coincident tick so a paused count never slips.
  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    pre_nxt   = pre;
    if (Load) begin
      q_nxt     = D;
      pre_nxt   = '0;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (Q != '0) begin
              state_nxt = ST_RUN;
              pre_nxt   = '0;
            end else begin
              state_nxt = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (Pause) begin
            state_nxt = ST_PAUSED;
          end else if (tick) begin
            pre_nxt = '0;
            q_nxt   = Q - WIDTH'(1);
            if (Q == WIDTH'(1)) state_nxt = ST_DONE;
          end else begin
            pre_nxt = pre + PRE_W'(1);
          end
        end
        ST_PAUSED: begin
          if (!Pause) state_nxt = ST_RUN;
        end
        ST_DONE: begin
          state_nxt = ST_DONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state   <= ST_IDLE;
      Q       <= '0;
      pre     <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      Q       <= q_nxt;
      pre     <= pre_nxt;
      Running <= (state_nxt == ST_RUN);
      Done    <= (state_nxt == ST_DONE);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    hex_to_seg u_seg (
      .nib (Q[i*DIGIT_W +: DIGIT_W]),
      .seg (seg[i])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];

endmodule
